// File: rtl/ant_pkg.sv
// Shared definitions for the ant maze: move encoding and recorder FSM states.
package ant_pkg;

    localparam logic [1:0] FWD    = 2'b00;
    localparam logic [1:0] TURN_R = 2'b01;
    localparam logic [1:0] TURN_L = 2'b10;
    localparam logic [1:0] STAY   = 2'b11;

    typedef enum logic [1:0] {
        StRec    = 2'd0,
        StReplay = 2'd1,
        StDone   = 2'd2
    } ant_state_e;

    // Opposite turns back to back undo each other.
    function automatic logic is_cancel(logic [1:0] mv, logic [1:0] top);
        return ((mv == TURN_R) && (top == TURN_L)) || ((mv == TURN_L) && (top == TURN_R));
    endfunction

endpackage

// File: rtl/ant_path_stack.sv
// Path storage: a register stack with push/pop, a top-of-stack view and an
// indexed read port used for oldest-first replay. Data words have no reset.
module ant_path_stack
    import ant_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [1:0]    wr_data_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [1:0]    top_o,
    output logic [1:0]    rd_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [1:0]    mem_q [DEPTH];
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] top_idx;

    // Stack pointer update; the caller never asks for push and pop together.
    always_comb begin
        count_d = count_q;
        if (pop_i) begin
            count_d = count_q - (AW+1)'(1);
        end else if (push_i) begin
            count_d = count_q + (AW+1)'(1);
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage write at the current fill level; push is only issued when not full.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[count_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Low bits wrap correctly when count == DEPTH (top index DEPTH-1).
    assign top_idx   = count_q[AW-1:0] - AW'(1);
    assign full_o    = count_q[AW];
    assign empty_o   = (count_q == '0);
    assign top_o     = empty_o ? FWD : mem_q[top_idx];
    assign rd_data_o = mem_q[rd_idx_i];
    assign count_o   = count_q;

endmodule

// File: rtl/ant_trail_recorder.sv
// Records the ant's net path (blocked moves dropped, opposite turns cancelled)
// and replays it oldest-first through a valid/request port once the ant escapes.
module ant_trail_recorder
    import ant_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  move,
    input  logic        hit,
    input  logic        escape,
    input  logic        rd_req,
    output logic        rd_valid,
    output logic [1:0]  rd_move,
    output logic [AW:0] count,
    output logic        overflow,
    output logic        done
);

    ant_state_e    state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    logic          push, pop;
    logic [1:0]    top_move, rd_data;
    logic          full, empty;
    logic [AW:0]   cnt_after;
    logic [AW:0]   rd_next;

    ant_path_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (move),
        .rd_idx_i  (rd_ptr_q),
        .top_o     (top_move),
        .rd_data_o (rd_data),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Next-state: record/cancel moves, pick the exit state on escape, advance replay.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;
        cnt_after  = count;
        // Wide enough to compare against count == DEPTH on the last read.
        rd_next    = {1'b0, rd_ptr_q} + (AW+1)'(1);
        case (state_q)
            StRec: begin
                if ((move != STAY) && !hit) begin
                    // Cancel is checked before fullness so a full stack can still shrink.
                    if (!empty && is_cancel(move, top_move)) begin
                        pop       = 1'b1;
                        cnt_after = count - (AW+1)'(1);
                    end else if (!full) begin
                        push      = 1'b1;
                        cnt_after = count + (AW+1)'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (escape) begin
                    state_d = (cnt_after != '0) ? StReplay : StDone;
                end
            end
            StReplay: begin
                if (rd_req) begin
                    rd_ptr_d = rd_next[AW-1:0];
                    if (rd_next == count) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StRec;
            end
        endcase
    end

    // State, replay pointer and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRec;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_valid = (state_q == StReplay);
    assign rd_move  = rd_valid ? rd_data : FWD;
    assign done     = (state_q == StDone);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ant_trail_recorder.sv
// Self-checking bench for ant_trail_recorder: a table of recording vectors,
// hand-written corner sequences, and randomized record/replay runs checked
// against a queue-based path model.
module tb_ant_trail_recorder;
    import ant_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    move;
    logic          hit;
    logic          escape;
    logic          rd_req;
    logic          rd_valid;
    logic [1:0]    rd_move;
    logic [AW:0]   count;
    logic          overflow;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Reference model: the net path as a queue, plus the sticky overflow flag.
    logic [1:0] mq[$];
    logic       m_ovf;

    typedef struct {
        logic [1:0] mv;
        logic       hit;
        int         exp_count;
    } vec_t;

    vec_t tbl [14];

    ant_trail_recorder #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .move     (move),
        .hit      (hit),
        .escape   (escape),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_move  (rd_move),
        .count    (count),
        .overflow (overflow),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] mv, input logic h, input logic e, input logic r);
        move   = mv;
        hit    = h;
        escape = e;
        rd_req = r;
    endtask

    task automatic model_rec(input logic [1:0] mv, input logic h);
        if (mv == STAY || h) begin
            // blocked or idle: path unchanged
        end else if (mq.size() > 0 &&
                     ((mv == TURN_R && mq[$] == TURN_L) || (mv == TURN_L && mq[$] == TURN_R))) begin
            void'(mq.pop_back());
        end else if (mq.size() < DEPTH) begin
            mq.push_back(mv);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rd_valid"}, 32'(rd_valid), 0);
        chk({name, "_rd_move"}, 32'(rd_move), 0);
        chk({name, "_count"}, 32'(count), 0);
        chk({name, "_overflow"}, 32'(overflow), 0);
        chk({name, "_done"}, 32'(done), 0);
    endtask

    task automatic do_reset();
        drive(STAY, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst");
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply one recording move (no escape), then compare count/overflow with the model.
    task automatic rec(input string name, input logic [1:0] mv, input logic h);
        drive(mv, h, 1'b0, 1'b0);
        model_rec(mv, h);
        tick();
        chk({name, "_count"}, 32'(count), mq.size());
        chk({name, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Drain the replay port, comparing each entry with the model path; inputs that
    // replay must ignore are randomized while reading.
    task automatic replay_check(input string name, input bit rand_req);
        int   idx = 0;
        int   cyc = 0;
        logic r;
        while (idx < mq.size() && cyc < 4 * DEPTH + 8) begin
            chk({name, "_valid"}, 32'(rd_valid), 1);
            chk({name, "_move"}, 32'(rd_move), 32'(mq[idx]));
            chk({name, "_count"}, 32'(count), mq.size());
            r = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), r);
            tick();
            if (r) idx++;
            cyc++;
        end
        chk({name, "_drained"}, idx, mq.size());
        chk({name, "_done"}, 32'(done), 1);
        chk({name, "_valid_low"}, 32'(rd_valid), 0);
        chk({name, "_move_low"}, 32'(rd_move), 0);
        chk({name, "_ovf_hold"}, 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [1:0] exp_a [3];
        rst_n = 1'b0;
        drive(STAY, 1'b0, 1'b0, 1'b0);
        m_ovf = 1'b0;

        // Recording table: hand-derived running count after each move.
        tbl[0]  = '{FWD,    1'b0, 1};
        tbl[1]  = '{FWD,    1'b1, 1};
        tbl[2]  = '{STAY,   1'b0, 1};
        tbl[3]  = '{TURN_R, 1'b0, 2};
        tbl[4]  = '{TURN_L, 1'b0, 1};
        tbl[5]  = '{TURN_L, 1'b0, 2};
        tbl[6]  = '{TURN_R, 1'b0, 1};
        tbl[7]  = '{TURN_R, 1'b0, 2};
        tbl[8]  = '{TURN_R, 1'b0, 3};
        tbl[9]  = '{TURN_L, 1'b1, 3};
        tbl[10] = '{TURN_L, 1'b0, 2};
        tbl[11] = '{TURN_L, 1'b0, 1};
        tbl[12] = '{FWD,    1'b0, 2};
        tbl[13] = '{STAY,   1'b1, 2};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].mv, tbl[i].hit, 1'b0, 1'b0);
            model_rec(tbl[i].mv, tbl[i].hit);
            tick();
            chk("tbl_count", 32'(count), tbl[i].exp_count);
            chk("tbl_rd_valid", 32'(rd_valid), 0);
        end
        drive(STAY, 1'b0, 1'b1, 1'b0);
        tick();
        replay_check("tbl_replay", 1'b0);

        // Push then replay with fixed expected entries and N+1 done timing.
        do_reset();
        rec("a_rec", FWD, 1'b0);
        rec("a_rec", TURN_R, 1'b0);
        rec("a_rec", FWD, 1'b0);
        drive(STAY, 1'b0, 1'b1, 1'b0);
        tick();
        chk("a_count", 32'(count), 3);
        exp_a[0] = FWD;
        exp_a[1] = TURN_R;
        exp_a[2] = FWD;
        drive(STAY, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("a_valid", 32'(rd_valid), 1);
            chk("a_move", 32'(rd_move), 32'(exp_a[i]));
            chk("a_done_early", 32'(done), 0);
            tick();
        end
        chk("a_done", 32'(done), 1);
        chk("a_valid_low", 32'(rd_valid), 0);

        // Cancel.
        do_reset();
        rec("b_rec", TURN_R, 1'b0);
        rec("b_rec", TURN_L, 1'b0);
        rec("b_rec", FWD, 1'b0);
        chk("b_count", 32'(count), 1);
        drive(STAY, 1'b0, 1'b1, 1'b0);
        tick();
        replay_check("b_replay", 1'b0);

        // Blocked and idle.
        do_reset();
        rec("c_rec", FWD, 1'b1);
        rec("c_rec", STAY, 1'b0);
        rec("c_rec", FWD, 1'b0);
        chk("c_count", 32'(count), 1);

        // Full: overflow on lost pushes; TURN_R cannot cancel FWD.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) rec("d_fill", FWD, 1'b0);
        chk("d_count_full", 32'(count), DEPTH);
        chk("d_ovf", 32'(overflow), 1);
        rec("d_turn", TURN_R, 1'b0);
        chk("d_count_stays", 32'(count), DEPTH);

        // Cancel on a full stack is accepted without overflow.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) rec("d2_fill", FWD, 1'b0);
        rec("d2_last", TURN_R, 1'b0);
        chk("d2_full", 32'(count), DEPTH);
        rec("d2_cancel", TURN_L, 1'b0);
        chk("d2_after_cancel", 32'(count), DEPTH - 1);
        chk("d2_no_ovf", 32'(overflow), 0);
        drive(STAY, 1'b0, 1'b1, 1'b0);
        tick();
        replay_check("d2_replay", 1'b1);

        // Zero-length escape; later inputs and rd_req have no effect.
        do_reset();
        drive(STAY, 1'b0, 1'b1, 1'b0);
        tick();
        chk("e_done", 32'(done), 1);
        chk("e_valid", 32'(rd_valid), 0);
        for (int i = 0; i < 4; i++) begin
            drive(FWD, 1'b0, 1'b1, 1'b1);
            tick();
            chk("e_done_hold", 32'(done), 1);
            chk("e_valid_hold", 32'(rd_valid), 0);
            chk("e_count_hold", 32'(count), 0);
        end

        // Escape cycle whose own cancel empties the path goes straight to done.
        do_reset();
        rec("e2_rec", TURN_R, 1'b0);
        drive(TURN_L, 1'b0, 1'b1, 1'b0);
        tick();
        chk("e2_count", 32'(count), 0);
        chk("e2_done", 32'(done), 1);
        chk("e2_valid", 32'(rd_valid), 0);

        // Reset mid-replay.
        do_reset();
        rec("f_rec", FWD, 1'b0);
        rec("f_rec", TURN_R, 1'b0);
        rec("f_rec", TURN_R, 1'b0);
        rec("f_rec", FWD, 1'b0);
        rec("f_rec", TURN_L, 1'b0);
        chk("f_count", 32'(count), 5);
        drive(STAY, 1'b0, 1'b1, 1'b0);
        tick();
        drive(STAY, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("f_third", 32'(rd_move), 32'(TURN_R));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("f_async");
        mq.delete();
        m_ovf = 1'b0;
        drive(STAY, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rec("f_restart", FWD, 1'b0);
        chk("f_restart_count", 32'(count), 1);

        // Randomized record/escape/replay runs against the path model.
        for (int it = 0; it < 40; it++) begin
            logic [1:0] mv;
            logic       h;
            int         len;
            do_reset();
            len = $urandom_range(0, 3 * DEPTH);
            for (int k = 0; k < len; k++) begin
                mv = 2'($urandom_range(0, 3));
                h  = ($urandom_range(0, 3) == 0);
                rec("rnd_rec", mv, h);
            end
            mv = 2'($urandom_range(0, 3));
            h  = ($urandom_range(0, 3) == 0);
            drive(mv, h, 1'b1, 1'b0);
            model_rec(mv, h);
            tick();
            chk("rnd_esc_count", 32'(count), mq.size());
            chk("rnd_esc_ovf", 32'(overflow), 32'(m_ovf));
            if (mq.size() == 0) begin
                chk("rnd_empty_done", 32'(done), 1);
                chk("rnd_empty_valid", 32'(rd_valid), 0);
            end else begin
                replay_check("rnd_replay", 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
